// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types and constants for the core control unit.
//   state_t   - control FSM states
//   OPC_*     - supported major opcodes
//   INST_*    - full-word encodings (EBREAK, NOP)
//   wb_t      - write-back bundle produced by wb_calc()
package core_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_WB    = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0]  OPC_JALR    = 7'b1100111;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_NOP    = 32'h0000_0013;

   typedef struct packed {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] next_pc;
   } wb_t;

   // Write-back result for a legal non-EBREAK instruction.
   function automatic wb_t wb_calc(input logic [31:0] inst,
                                   input logic [31:0] pc,
                                   input logic [31:0] alu);
      wb_t        r;
      logic [31:0] pc4;
      pc4       = pc + 32'd4;
      r.waddr   = inst[11:7];
      r.wen     = (inst[11:7] != 5'd0);
      r.wdata   = 32'd0;
      r.next_pc = pc4;
      case (inst[6:0])
         OPC_OP_IMM: begin
            r.wdata   = alu;
            r.next_pc = pc4;
         end
         OPC_JALR: begin
            r.wdata   = pc4;
            r.next_pc = {alu[31:1], 1'b0};
         end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/core_ctrl_fetch_timer.sv
// fetch_timer: fetch-wait counter.
//   clk, reset - clock, synchronous active-high reset
//   clr        - hold counter at zero (asserted outside FETCH)
//   en         - count this cycle (FETCH without imem_valid)
//   expire     - current cycle is the LIMIT-th waiting cycle
module fetch_timer #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);
   import core_ctrl_pkg::*;

   localparam logic [7:0] LAST = 8'(LIMIT - 1);

   logic [7:0] cnt;

   // cnt holds the number of FETCH cycles already elapsed, so it reads
   // LIMIT-1 during the LIMIT-th cycle; that is when expiry is flagged.
   assign expire = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= 8'd0;
      else if (en && !expire)
         cnt <= cnt + 8'd1;
   end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: FETCH/EXEC/WB/HALT control unit for a single-issue core.
//   clk, reset          - clock, synchronous active-high reset
//   imem_req/addr       - fetch request (addr = pc)
//   imem_valid/rdata    - fetch response
//   inst                - latched instruction to the decoder
//   alu_result          - rs1+imm for inst
//   pc                  - architectural PC
//   rf_wen/waddr/wdata  - register-file write port
//   retire, instret     - retire pulse and counter
//   halt/illegal/bus_err- sticky stop reasons
module core_ctrl #(
   parameter logic [31:0] RESET_PC      = 32'h8000_0000,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   input  logic [31:0] alu_result,
   output logic [31:0] pc,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        retire,
   output logic [31:0] instret,
   output logic        halt,
   output logic        illegal,
   output logic        bus_err
);
   import core_ctrl_pkg::*;

   state_t state_q, state_d;
   logic   tmo_expire;
   logic   is_ebreak, is_legal;
   wb_t    wb;

   assign is_ebreak = (inst == INST_EBREAK);
   assign is_legal  = (inst[6:0] == OPC_OP_IMM) || (inst[6:0] == OPC_JALR);
   assign wb        = wb_calc(inst, pc, alu_result);

   fetch_timer #(.LIMIT(FETCH_TIMEOUT)) u_fetch_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (state_q != ST_FETCH),
      .en     ((state_q == ST_FETCH) && !imem_valid),
      .expire (tmo_expire)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_FETCH;
      else
         state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            // a valid arriving in the expiry cycle still wins
            if (imem_valid)      state_d = ST_EXEC;
            else if (tmo_expire) state_d = ST_HALT;
         end
         ST_EXEC:  state_d = (is_ebreak || !is_legal) ? ST_HALT : ST_WB;
         ST_WB:    state_d = ST_FETCH;
         default:  state_d = ST_HALT;
      endcase
   end

   // outputs; forced idle while reset is asserted
   always_comb begin
      imem_req = 1'b0;
      rf_wen   = 1'b0;
      rf_wdata = 32'd0;
      retire   = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC:  retire   = is_ebreak;
            ST_WB: begin
               rf_wen   = wb.wen;
               rf_wdata = wb.wdata;
               retire   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign imem_addr = pc;
   assign rf_waddr  = inst[11:7];

   // architectural state and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         inst    <= INST_NOP;
         instret <= 32'd0;
         halt    <= 1'b0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         if (retire)
            instret <= instret + 32'd1;
         case (state_q)
            ST_FETCH: begin
               if (imem_valid)      inst    <= imem_rdata;
               else if (tmo_expire) bus_err <= 1'b1;
            end
            ST_EXEC: begin
               if (is_ebreak)      halt    <= 1'b1;
               else if (!is_legal) illegal <= 1'b1;
            end
            ST_WB:   pc <= wb.next_pc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed stimulus with a retire scoreboard for core_ctrl.
module tb_core_ctrl;

   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] inst;
   logic [31:0] alu_result = 32'd0;
   logic [31:0] pc;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        retire;
   logic [31:0] instret;
   logic        halt, illegal, bus_err;

   core_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(255)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .inst(inst), .alu_result(alu_result), .pc(pc),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .retire(retire), .instret(instret),
      .halt(halt), .illegal(illegal), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic [31:0] instret;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic void push(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [31:0] p, input logic [31:0] ir);
      exp_t e;
      e.wen = wen; e.waddr = wa; e.wdata = wd; e.pc = p; e.instret = ir;
      q.push_back(e);
   endfunction

   // monitor: every retire pulse is matched against the next expected record
   always @(negedge clk) begin
      if (retire === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_retire", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("ret_wen",     {31'd0, rf_wen}, {31'd0, e.wen});
            chk("ret_waddr",   {27'd0, rf_waddr}, {27'd0, e.waddr});
            if (e.wen) chk("ret_wdata", rf_wdata, e.wdata);
            chk("ret_pc",      pc, e.pc);
            chk("ret_instret", instret, e.instret);
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_req",     {31'd0, imem_req}, 32'd0);
      chk("rst_wen_ret", {30'd0, rf_wen, retire}, 32'd0);
      chk("rst_pc",      pc, RPC);
      chk("rst_inst",    inst, 32'h0000_0013);
      chk("rst_instret", instret, 32'd0);
      chk("rst_flags",   {29'd0, halt, illegal, bus_err}, 32'd0);
      reset = 1'b0;
      #1;
   endtask

   // present one instruction once imem_req is seen, after 'delay' idle cycles;
   // returns at the negedge of the EXEC cycle
   task automatic issue(input logic [31:0] ins, input logic [31:0] alu, input int delay);
      int n = 0;
      while (imem_req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (imem_req !== 1'b1) begin
         chk("req_timeout", {31'd0, imem_req}, 32'd1);
         return;
      end
      repeat (delay) @(negedge clk);
      imem_valid = 1'b1;
      imem_rdata = ins;
      alu_result = alu;
      @(negedge clk);
      imem_valid = 1'b0;
   endtask

   initial begin
      do_reset();

      // addi x1,x0,5: retire in the third cycle
      push(1'b1, 5'd1, 32'd5, RPC, 32'd0);
      issue(32'h0050_0093, 32'd5, 0);
      @(negedge clk);
      chk("lat_retire", {31'd0, retire}, 32'd1);

      // jalr x2: link pc+4, target with bit 0 cleared
      push(1'b1, 5'd2, 32'h8000_0008, 32'h8000_0004, 32'd1);
      issue(32'h0000_8167, 32'h8000_0101, 0);

      // addi x0: no write, still retires; fetch waits 3 cycles
      push(1'b0, 5'd0, 32'd0, 32'h8000_0100, 32'd2);
      issue(32'h0000_0013, 32'h0000_1234, 3);

      // addi x3,x0,7 with stray imem_valid during EXEC and WB
      push(1'b1, 5'd3, 32'd7, 32'h8000_0104, 32'd3);
      issue(32'h0070_0193, 32'd7, 0);
      imem_valid = 1'b1;
      imem_rdata = 32'h0000_0033;
      @(negedge clk);
      @(negedge clk);
      imem_valid = 1'b0;
      chk("stray_inst", inst, 32'h0070_0193);
      chk("stray_pc",   pc, 32'h8000_0108);

      // illegal opcode 0110011
      issue(32'h0000_0033, 32'd0, 0);
      repeat (3) @(negedge clk);
      chk("ill_flag",    {31'd0, illegal}, 32'd1);
      chk("ill_req",     {31'd0, imem_req}, 32'd0);
      chk("ill_pc",      pc, 32'h8000_0108);
      chk("ill_instret", instret, 32'd4);
      chk("ill_buserr",  {31'd0, bus_err}, 32'd0);

      // reset from HALT
      do_reset();
      chk("hrst_flags",   {29'd0, halt, illegal, bus_err}, 32'd0);
      chk("hrst_req",     {31'd0, imem_req}, 32'd1);

      // ebreak: retires from EXEC, halts, pc unchanged
      push(1'b0, 5'd0, 32'd0, RPC, 32'd0);
      issue(32'h0010_0073, 32'd0, 0);
      repeat (2) @(negedge clk);
      chk("ebk_halt",    {31'd0, halt}, 32'd1);
      chk("ebk_instret", instret, 32'd1);
      chk("ebk_pc",      pc, RPC);
      chk("ebk_req",     {31'd0, imem_req}, 32'd0);
      chk("ebk_illegal", {31'd0, illegal}, 32'd0);

      // reset asserted in EXEC
      do_reset();
      issue(32'h0050_0093, 32'd5, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("xrst_wen_ret", {30'd0, rf_wen, retire}, 32'd0);
      reset = 1'b0;
      #1;
      chk("xrst_req",     {31'd0, imem_req}, 32'd1);
      chk("xrst_pc",      pc, RPC);
      chk("xrst_instret", instret, 32'd0);

      // fetch timeout: still fetching in cycle 255, halted after it
      do_reset();
      repeat (254) @(negedge clk);
      chk("tmo_pre_req", {31'd0, imem_req}, 32'd1);
      chk("tmo_pre_err", {31'd0, bus_err}, 32'd0);
      @(negedge clk);
      chk("tmo_err",     {31'd0, bus_err}, 32'd1);
      chk("tmo_req",     {31'd0, imem_req}, 32'd0);
      chk("tmo_pc",      pc, RPC);

      // valid exactly in cycle 255 wins over the timeout
      do_reset();
      repeat (254) @(negedge clk);
      push(1'b1, 5'd5, 32'd9, RPC, 32'd0);
      issue(32'h0090_0293, 32'd9, 0);
      repeat (3) @(negedge clk);
      chk("edge_err",     {31'd0, bus_err}, 32'd0);
      chk("edge_pc",      pc, 32'h8000_0004);
      chk("edge_instret", instret, 32'd1);
      chk("sb_empty",     q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
